io_vector_player: RTL and testbench
===================================

IO_VECTOR_PLAYER -- requirements
Module: io_vector_player

Interface
REQ-001 Parameter IN_W, default 16, stimulus width (ui_in and uio_in concatenated).
REQ-002 Parameter OUT_W, default 8, compared DUT output width.
REQ-003 Parameter DEPTH, default 16, vector table entries; AW = clog2(DEPTH).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 wr_en  in  1  table write strobe.
REQ-007 wr_addr  in  AW  table write address.
REQ-008 wr_stim  in  IN_W  stimulus word to store.
REQ-009 wr_exp  in  OUT_W  expected response to store.
REQ-010 wr_mask  in  OUT_W  compare mask to store; 1 = bit checked.
REQ-011 start  in  1  run request.
REQ-012 loop_en  in  1  repeat the table until deasserted.
REQ-013 last_addr  in  AW  index of final vector.
REQ-014 lat  in  4  extra settle cycles before compare.
REQ-015 dut_out  in  OUT_W  DUT response.
REQ-016 stim  out  IN_W  registered stimulus to DUT.
REQ-017 busy  out  1  high in APPLY, WAIT and CHECK.
REQ-018 done  out  1  high in DONE.
REQ-019 pass  out  1  valid while done; 1 = err_cnt is zero.
REQ-020 err_cnt  out  8  saturating mismatch count.
REQ-021 err_addr  out  AW  address of the first mismatching vector.

Function
REQ-022 States SHALL be IDLE, APPLY, WAIT, CHECK and DONE.
REQ-023 IDLE/DONE with start=1: addr<=0, err_cnt<=0, err_addr<=0, first-error flag cleared, last_addr and lat latched, next state APPLY.
REQ-024 APPLY: stim<=table_stim[addr]; settle counter<=latched lat; next WAIT if lat>0, else CHECK.
REQ-025 WAIT: decrement counter; go to CHECK when counter reaches 1.
REQ-026 CHECK: mismatch = |((dut_out ^ exp[addr]) & mask[addr]).
REQ-027 On mismatch, err_cnt SHALL increment and hold at 255.
REQ-028 On the first mismatch of a run, err_addr<=addr; later mismatches leave err_addr unchanged.
REQ-029 CHECK with addr != latched last_addr: addr<=addr+1, next APPLY.
REQ-030 CHECK with addr == latched last_addr: if loop_en=1, addr<=0 and next APPLY with err_cnt kept; else next DONE.
REQ-031 Each vector SHALL take lat+2 cycles, so done rises N*(lat+2)+1 cycles after the start edge (N = last_addr+1).
REQ-032 stim SHALL hold its last value in WAIT, CHECK and DONE.
REQ-033 DONE: pass = (err_cnt==0); state held until start.
REQ-034 start while busy SHALL be ignored.
REQ-035 wr_en while busy SHALL be ignored.
REQ-036 Writes are accepted in IDLE/DONE.
REQ-037 A write and start in the same cycle SHALL both take effect; the first APPLY SHALL read the new data.
REQ-038 Deasserting loop_en mid-pass SHALL finish the current pass, then enter DONE.

Reset
REQ-039 rst=1: state IDLE; stim, err_cnt and err_addr set to 0; busy, done and pass set to 0; takes effect on the next edge, also mid-run.
REQ-040 Table contents SHALL NOT be reset.

Structure
REQ-041 Package io_player_pkg SHALL hold the state enum and the ERR_W=8 and LAT_W=4 constants.
REQ-042 Sub-module io_vector_mem SHALL be a DEPTH x (IN_W+2*OUT_W) register array with a synchronous write port and a combinational read port.

Verification
REQ-043 Scenario 1: 4 vectors, dut_out=stim[7:0], exp=stim[7:0], mask=FF, lat=0 -> done 9 cycles after start, pass=1, err_cnt=0.
REQ-044 Scenario 2: vector 2 expected value with bit 3 flipped -> err_cnt=1, err_addr=2, pass=0; rerun with mask bit 3 = 0 -> pass=1.
REQ-045 Scenario 3: DUT model with 3-cycle delay -> lat=3 gives pass=1; lat=2 gives pass=0 and err_addr=0.
REQ-046 Scenario 4: loop_en=1 with one failing vector for 300 passes -> err_cnt=255; drop loop_en -> done at end of the current pass.
REQ-047 Scenario 5: rst during WAIT -> next cycle stim=0, busy=0, err_cnt=0.
REQ-048 Scenario 6: start or wr_en while busy -> run unaffected and table unchanged.

Source files
------------

// File: rtl/io_player_pkg.sv
// Shared types and constants for the IO vector player: FSM states and
// the error-counter / settle-latency widths.
package io_player_pkg;

  localparam int ERR_W = 8;
  localparam int LAT_W = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/io_vector_mem.sv
// Vector table: DEPTH words of {stim, exp, mask}, synchronous write,
// combinational read. Contents are deliberately not reset.
module io_vector_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/io_vector_player.sv
// Replays a table of stimulus vectors into a DUT, waits a programmable
// settle time, then compares the masked response against the expected word.
import io_player_pkg::*;

module io_vector_player #(
  parameter  int IN_W  = 16,
  parameter  int OUT_W = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [IN_W-1:0]  wr_stim,
  input  logic [OUT_W-1:0] wr_exp,
  input  logic [OUT_W-1:0] wr_mask,
  input  logic             start,
  input  logic             loop_en,
  input  logic [AW-1:0]    last_addr,
  input  logic [LAT_W-1:0] lat,
  input  logic [OUT_W-1:0] dut_out,
  output logic [IN_W-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [AW-1:0]    err_addr,
  output logic [2:0]       dbg_state
);

  localparam int W = IN_W + 2 * OUT_W;

  // Handshake: start is sampled only in IDLE/DONE; busy is high for the
  // whole run (start and writes are ignored then); done holds until the next start.
  state_t           state, state_d;
  logic [AW-1:0]    addr, last_q;
  logic [LAT_W-1:0] lat_q, settle;
  logic             err_seen;
  logic [W-1:0]     rd_data;
  logic [IN_W-1:0]  rd_stim;
  logic [OUT_W-1:0] rd_exp, rd_mask;
  logic             mismatch, mem_we;

  assign mem_we = wr_en && !busy;

  io_vector_mem #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_addr),
    .wr_data ({wr_stim, wr_exp, wr_mask}),
    .rd_addr (addr),
    .rd_data (rd_data)
  );

  assign rd_stim  = rd_data[W-1 -: IN_W];
  assign rd_exp   = rd_data[2*OUT_W-1 -: OUT_W];
  assign rd_mask  = rd_data[OUT_W-1:0];
  assign mismatch = |((dut_out ^ rd_exp) & rd_mask);

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (start) state_d = APPLY;
      APPLY:      state_d = (lat_q != '0) ? WAIT : CHECK;
      WAIT:       if (settle == LAT_W'(1)) state_d = CHECK;
      CHECK:      state_d = (addr != last_q || loop_en) ? APPLY : DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      stim     <= '0;
      err_cnt  <= '0;
      err_addr <= '0;
      err_seen <= 1'b0;
      addr     <= '0;
      last_q   <= '0;
      lat_q    <= '0;
      settle   <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr     <= '0;
            err_cnt  <= '0;
            err_addr <= '0;
            err_seen <= 1'b0;
            last_q   <= last_addr;
            lat_q    <= lat;
          end
        end
        APPLY: begin
          stim   <= rd_stim;
          settle <= lat_q;
        end
        WAIT: settle <= settle - LAT_W'(1);
        CHECK: begin
          // err_addr records only the first failure of the whole run, across loop passes.
          if (mismatch) begin
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
            if (!err_seen) begin
              err_seen <= 1'b1;
              err_addr <= addr;
            end
          end
          if (addr != last_q) addr <= addr + AW'(1);
          else if (loop_en)   addr <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == APPLY) || (state == WAIT) || (state == CHECK);
  assign done      = (state == DONE);
  assign pass      = done && (err_cnt == '0);
  assign dbg_state = state;

endmodule

// File: tb/tb_io_vector_player.sv
// Directed-plus-random bench for io_vector_player; a vector-level reference
// model predicts error count, first failing address and completion time.
module tb_io_vector_player;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, loop_en;
  logic [3:0]  wr_addr, last_addr, lat, err_addr;
  logic [15:0] wr_stim, stim;
  logic [7:0]  wr_exp, wr_mask, dut_out, err_cnt;
  logic        busy, done, pass;
  logic [2:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] t_stim [16];
  logic [7:0]  t_exp  [16];
  logic [7:0]  t_mask [16];
  logic [15:0] m_prev;
  logic [15:0] exp_q [$];

  // DUT under test: combinational fold of stim, or the same through 3 registers
  logic       dly_sel = 1'b0;
  logic [7:0] p1, p2, p3;

  function automatic logic [7:0] f8(input logic [15:0] s);
    return s[7:0] ^ s[15:8];
  endfunction

  always @(posedge clk) begin
    p1 <= f8(stim);
    p2 <= p1;
    p3 <= p2;
  end
  assign dut_out = dly_sel ? p3 : f8(stim);

  io_vector_player dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
    .wr_exp(wr_exp), .wr_mask(wr_mask), .start(start), .loop_en(loop_en),
    .last_addr(last_addr), .lat(lat), .dut_out(dut_out), .stim(stim),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .err_addr(err_addr), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic stage_write(input int a, input logic [15:0] s, input logic [7:0] e,
                             input logic [7:0] m);
    wr_en = 1'b1; wr_addr = AW'(a); wr_stim = s; wr_exp = e; wr_mask = m;
    t_stim[a] = s; t_exp[a] = e; t_mask[a] = m;
  endtask

  task automatic write_vec(input int a, input logic [15:0] s, input logic [7:0] e,
                           input logic [7:0] m);
    stage_write(a, s, e, m);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic run(input int n, input int lat_v, input bit lp, input int budget,
                     output int cyc);
    last_addr = AW'(n - 1); lat = 4'(lat_v); loop_en = lp; start = 1'b1; cyc = 0;
    while (cyc < budget) begin
      tick();
      cyc++;
      start = 1'b0; wr_en = 1'b0;
      if (done) break;
    end
    chk("run_done", 32'(done), 32'd1);
  endtask

  // reference model: one entry {first_fail_addr, err_cnt} per run
  task automatic model_run(input int n, input int lat_v, input int passes, input int dly);
    logic [15:0] prev;
    logic [7:0]  seen;
    int cnt, first;
    cnt = 0; first = -1; prev = m_prev;
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < n; k++) begin
        // a delayed DUT has caught up only if the settle time covers its latency
        seen = (lat_v >= dly) ? f8(t_stim[k]) : f8(prev);
        if (((seen ^ t_exp[k]) & t_mask[k]) != 8'h00) begin
          if (first < 0) first = k;
          if (cnt < 255) cnt++;
        end
        prev = t_stim[k];
      end
    m_prev = prev;
    exp_q.push_back({8'((first < 0) ? 0 : first), 8'(cnt)});
  endtask

  task automatic run_and_check(input string tag, input int n, input int lat_v, input int dly);
    int cyc;
    logic [15:0] e;
    model_run(n, lat_v, 1, dly);
    dly_sel = (dly != 0);
    run(n, lat_v, 1'b0, n * (lat_v + 2) + 20, cyc);
    e = exp_q.pop_front();
    chk({tag, "_cycles"}, 32'(cyc), 32'(n * (lat_v + 2) + 1));
    chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(e[7:0]));
    chk({tag, "_err_addr"}, 32'(err_addr), 32'(e[15:8]));
    chk({tag, "_pass"}, 32'(pass), 32'(e[7:0] == 8'd0));
    chk({tag, "_stim_hold"}, 32'(stim), 32'(t_stim[n-1]));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cyc;
    logic [15:0] s, e;
    bit clash;

    rst = 1'b1; wr_en = 1'b0; start = 1'b0; loop_en = 1'b0;
    wr_addr = '0; wr_stim = '0; wr_exp = '0; wr_mask = '0; last_addr = '0; lat = '0;
    m_prev = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_stim", 32'(stim), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_err_addr", 32'(err_addr), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);

    // Scenario 1: four matching vectors with distinct responses
    for (int k = 0; k < 4; k++) begin
      do begin
        s = 16'($urandom);
        clash = 1'b0;
        for (int j = 0; j < k; j++) if (f8(t_stim[j]) == f8(s)) clash = 1'b1;
      end while (clash);
      write_vec(k, s, f8(s), 8'hFF);
    end
    run_and_check("s1", 4, 0, 0);
    chk("s1_pass_abs", 32'(pass), 32'd1);

    // Scenario 2: flip bit 3 of vector 2's expectation, then mask it away
    write_vec(2, t_stim[2], t_exp[2] ^ 8'h08, 8'hFF);
    run_and_check("s2_bad", 4, 0, 0);
    chk("s2_err_addr_abs", 32'(err_addr), 32'd2);
    stage_write(2, t_stim[2], t_exp[2], 8'hF7);
    run_and_check("s2_masked", 4, 0, 0);
    // a write to vector 0 alongside start must be seen by the first APPLY
    stage_write(0, t_stim[0], t_exp[0] ^ 8'h40, 8'hFF);
    run_and_check("s2_wr_start", 4, 0, 0);
    chk("s2_wr_start_addr", 32'(err_addr), 32'd0);
    write_vec(0, t_stim[0], f8(t_stim[0]), 8'hFF);

    // Scenario 3: DUT with three cycles of latency
    run_and_check("s3_lat3", 4, 3, 3);
    chk("s3_lat3_pass", 32'(pass), 32'd1);
    run_and_check("s3_lat2", 4, 2, 3);
    chk("s3_lat2_pass", 32'(pass), 32'd0);
    chk("s3_lat2_addr", 32'(err_addr), 32'd0);

    // random tables and run shapes
    for (int k = 0; k < 8; k++) begin
      s = 16'($urandom);
      write_vec(k, s, f8(s) ^ (($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00),
                8'($urandom));
    end
    for (int r = 0; r < 5; r++)
      run_and_check("rnd", $urandom_range(1, 8), $urandom_range(0, 6),
                    3 * $urandom_range(0, 1));

    // Scenario 4: 301 looped passes with vector 1 failing, loop dropped mid-pass
    write_vec(0, t_stim[0], f8(t_stim[0]), 8'hFF);
    write_vec(1, t_stim[1], f8(t_stim[1]) ^ 8'h01, 8'hFF);
    dly_sel = 1'b0;
    model_run(2, 0, 301, 0);
    last_addr = 4'd1; lat = 4'd0; loop_en = 1'b1; start = 1'b1; cyc = 0;
    while (cyc < 1300) begin
      tick();
      cyc++;
      start = 1'b0;
      if (cyc == 1100) begin
        chk("s4_mid_busy", 32'(busy), 32'd1);
        chk("s4_mid_sat", 32'(err_cnt), 32'd255);
      end
      if (cyc == 1203) loop_en = 1'b0;
      if (done) break;
    end
    e = exp_q.pop_front();
    chk("s4_cycles", 32'(cyc), 32'd1205);
    chk("s4_err_cnt", 32'(err_cnt), 32'(e[7:0]));
    chk("s4_err_addr", 32'(err_addr), 32'(e[15:8]));
    chk("s4_pass", 32'(pass), 32'd0);

    // Scenario 5: reset while waiting on vector 2
    last_addr = 4'd2; lat = 4'd5; start = 1'b1; cyc = 0;
    while (cyc < 18) begin
      tick();
      cyc++;
      start = 1'b0;
    end
    chk("s5_in_wait", 32'(dbg_state), 32'd2);
    chk("s5_err_before", 32'(err_cnt), 32'd1);
    chk("s5_stim_before", 32'(stim), 32'(t_stim[2]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_prev = '0;
    chk("s5_stim", 32'(stim), 32'd0);
    chk("s5_busy", 32'(busy), 32'd0);
    chk("s5_err_cnt", 32'(err_cnt), 32'd0);
    chk("s5_err_addr", 32'(err_addr), 32'd0);
    chk("s5_done", 32'(done), 32'd0);
    chk("s5_state", 32'(dbg_state), 32'd0);

    // Scenario 6: start and a write while busy are both ignored
    write_vec(1, t_stim[1], f8(t_stim[1]), 8'hFF);
    model_run(4, 1, 1, 0);
    last_addr = 4'd3; lat = 4'd1; loop_en = 1'b0; start = 1'b1; cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      start = 1'b0; wr_en = 1'b0;
      if (cyc == 3) begin
        start = 1'b1;
        wr_en = 1'b1; wr_addr = 4'd1; wr_stim = t_stim[1];
        wr_exp = ~f8(t_stim[1]); wr_mask = 8'hFF;
      end
      if (done) break;
    end
    e = exp_q.pop_front();
    chk("s6_cycles", 32'(cyc), 32'd13);
    chk("s6_err_cnt", 32'(err_cnt), 32'(e[7:0]));
    run_and_check("s6_rerun", 4, 1, 0);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
